dmem_responder: RTL and testbench

- Responder end of the core's data-memory interface. It answers `dmem_wready`/`dmem_rready` requests from the core-side router with `wvalid`/`rvalid`/`rresp`/`rdata`.
- Backed by an internal word-addressed RAM, with programmable wait states per channel and an error response for out-of-range addresses.
- Instantiated in the testbench/SoC shell beside the instruction memory. It connects to the top-level `dmem_*` ports.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_sram_1r1w.sv | 39 +++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   chan_state_t : per-channel handshake FSM encoding
//   RESP_OK/ERR  : read response codes
//   WAIT_W       : wait-state counter width
package dmem_pkg;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_WAIT   = 2'd1,
    CH_ACCEPT = 2'd2
  } chan_state_t;

  localparam logic        RESP_OK  = 1'b1;
  localparam logic        RESP_ERR = 1'b0;
  localparam int unsigned WAIT_W   = 4;

endpackage

// File: rtl/dmem_sram_1r1w.sv
// DEPTH_WORDS x 32 RAM, one byte-strobed synchronous write port and one
// synchronous read port. A read and write to the same word on the same edge
// return the old contents. Only the read register is reset; the array is not.
//   clk, reset          : clock, async active-high reset (read register only)
//   we, wstrb, waddr, wdata : write port
//   re, raddr, rdata    : read port, rdata updates the cycle after re
module dmem_sram_1r1w
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core data-memory interface.
//   clk, reset                     : clock, async active-high reset
//   wready/waddr/wdata/wstrb, wvalid : write request and accept strobe
//   rready/raddr, rvalid           : read request and accept strobe
//   rdata/rresp, rdata_vld         : read result, strobed the cycle after accept
// Each channel waits RD_WAIT/WR_WAIT cycles before accepting; addresses
// outside [ADDR_BASE, ADDR_BASE + DEPTH_WORDS*4) are accepted but writes are
// dropped and reads return RESP_ERR with zero data.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned RD_WAIT     = 0,
  parameter int unsigned WR_WAIT     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wready,
  output logic        wvalid,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        rready,
  output logic        rvalid,
  input  logic [31:0] raddr,
  output logic        rresp,
  output logic [31:0] rdata,
  output logic        rdata_vld
);

  localparam int unsigned       AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]       SPAN    = DEPTH_WORDS * 4;
  localparam logic [WAIT_W-1:0] RD_W    = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_W    = WAIT_W'(WR_WAIT);
  // The request cycle itself counts as the first wait cycle.
  localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(RD_WAIT - 1);
  localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WR_WAIT - 1);

  chan_state_t       wr_state, wr_state_nx, rd_state, rd_state_nx;
  logic [WAIT_W-1:0] wr_cnt, wr_cnt_nx, rd_cnt, rd_cnt_nx;
  logic              wr_go, rd_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= CH_IDLE;
      rd_state <= CH_IDLE;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
    end else begin
      wr_state <= wr_state_nx;
      rd_state <= rd_state_nx;
      wr_cnt   <= wr_cnt_nx;
      rd_cnt   <= rd_cnt_nx;
    end
  end

  // Accept lands exactly WAIT cycles after the request rises: WAIT=0 accepts
  // from IDLE, WAIT=1 skips the WAIT state, larger values count down in WAIT.
  always_comb begin
    wr_state_nx = wr_state;
    wr_cnt_nx   = wr_cnt;
    wr_go       = 1'b0;
    case (wr_state)
      CH_IDLE: if (wready) begin
        if (WR_W == '0) wr_go = 1'b1;
        else if (WR_W == WAIT_W'(1)) wr_state_nx = CH_ACCEPT;
        else begin
          wr_state_nx = CH_WAIT;
          wr_cnt_nx   = WR_LOAD;
        end
      end
      CH_WAIT: begin
        if (!wready) begin
          wr_state_nx = CH_IDLE;
          wr_cnt_nx   = '0;
        end else begin
          wr_cnt_nx = wr_cnt - 1'b1;
          if (wr_cnt == WAIT_W'(1)) wr_state_nx = CH_ACCEPT;
        end
      end
      CH_ACCEPT: begin
        wr_go       = 1'b1;
        wr_state_nx = CH_IDLE;
      end
      default: wr_state_nx = CH_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nx = rd_state;
    rd_cnt_nx   = rd_cnt;
    rd_go       = 1'b0;
    case (rd_state)
      CH_IDLE: if (rready) begin
        if (RD_W == '0) rd_go = 1'b1;
        else if (RD_W == WAIT_W'(1)) rd_state_nx = CH_ACCEPT;
        else begin
          rd_state_nx = CH_WAIT;
          rd_cnt_nx   = RD_LOAD;
        end
      end
      CH_WAIT: begin
        if (!rready) begin
          rd_state_nx = CH_IDLE;
          rd_cnt_nx   = '0;
        end else begin
          rd_cnt_nx = rd_cnt - 1'b1;
          if (rd_cnt == WAIT_W'(1)) rd_state_nx = CH_ACCEPT;
        end
      end
      CH_ACCEPT: begin
        rd_go       = 1'b1;
        rd_state_nx = CH_IDLE;
      end
      default: rd_state_nx = CH_IDLE;
    endcase
  end

  // Zero-wait accepts are combinational from the request, so gate with reset
  // to keep outputs low while reset is held.
  assign wvalid = wr_go & ~reset;
  assign rvalid = rd_go & ~reset;

  logic [31:0] wr_off, rd_off;
  logic        wr_in, rd_in, wr_fire, rd_fire;

  assign wr_off  = waddr - ADDR_BASE;
  assign rd_off  = raddr - ADDR_BASE;
  assign wr_in   = wr_off < SPAN;
  assign rd_in   = rd_off < SPAN;
  assign wr_fire = wvalid & wready;
  assign rd_fire = rvalid & rready;

  logic [31:0] ram_q;
  logic        rd_ok_q;

  dmem_sram_1r1w #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (wr_fire & wr_in),
    .wstrb(wstrb),
    .waddr(wr_off[AW+1:2]),
    .wdata(wdata),
    .re   (rd_fire & rd_in),
    .raddr(rd_off[AW+1:2]),
    .rdata(ram_q)
  );

  // ram_q only moves on an in-range read and rd_ok_q only on an accept, so
  // together they hold the last response between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ok_q   <= 1'b0;
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= rd_fire;
      if (rd_fire) rd_ok_q <= rd_in;
    end
  end

  assign rresp = rd_ok_q ? RESP_OK : RESP_ERR;
  assign rdata = rd_ok_q ? ram_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: zero-wait, 256-word window at 0x1000
  logic        w0_ready = 0, w0_valid, r0_ready = 0, r0_valid, r0_resp, r0_dvld;
  logic [31:0] w0_addr = 0, w0_data = 0, r0_addr = 0, r0_data;
  logic [3:0]  w0_strb = 0;
  // dut1: RD_WAIT=3, WR_WAIT=2, 256-word window at 0
  logic        w1_ready = 0, w1_valid, r1_ready = 0, r1_valid, r1_resp, r1_dvld;
  logic [31:0] w1_addr = 0, w1_data = 0, r1_addr = 0, r1_data;
  logic [3:0]  w1_strb = 0;

  dmem_responder #(
    .ADDR_BASE(32'h0000_1000), .DEPTH_WORDS(256), .RD_WAIT(0), .WR_WAIT(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .wready(w0_ready), .wvalid(w0_valid), .waddr(w0_addr), .wdata(w0_data), .wstrb(w0_strb),
    .rready(r0_ready), .rvalid(r0_valid), .raddr(r0_addr),
    .rresp(r0_resp), .rdata(r0_data), .rdata_vld(r0_dvld)
  );

  dmem_responder #(
    .ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(256), .RD_WAIT(3), .WR_WAIT(2)
  ) dut1 (
    .clk(clk), .reset(reset),
    .wready(w1_ready), .wvalid(w1_valid), .waddr(w1_addr), .wdata(w1_data), .wstrb(w1_strb),
    .rready(r1_ready), .rvalid(r1_valid), .raddr(r1_addr),
    .rresp(r1_resp), .rdata(r1_data), .rdata_vld(r1_dvld)
  );

  task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    w0_ready = 1; w0_addr = a; w0_data = d; w0_strb = s;
    @(posedge clk); #1;
    w0_ready = 0;
  endtask

  task automatic rd0(input logic [31:0] a, output logic [31:0] d, output logic ok, output logic vld);
    @(posedge clk); #1;
    r0_ready = 1; r0_addr = a;
    @(posedge clk); #1;
    r0_ready = 0;
    @(negedge clk);
    d = r0_data; ok = r0_resp; vld = r0_dvld;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    w1_ready = 1; w1_addr = a; w1_data = d; w1_strb = s;
    repeat (3) @(posedge clk);
    #1 w1_ready = 0;
  endtask

  task automatic rd1(input logic [31:0] a, output logic [31:0] d, output logic ok);
    @(posedge clk); #1;
    r1_ready = 1; r1_addr = a;
    repeat (4) @(posedge clk);
    #1 r1_ready = 0;
    @(negedge clk);
    d = r1_data; ok = r1_resp;
  endtask

  task automatic test_reset();
    logic [69:0] outs;
    w0_ready = 1; r0_ready = 1; w1_ready = 1; r1_ready = 1;
    repeat (2) @(negedge clk);
    outs = {w0_valid, r0_valid, r0_resp, r0_data, r0_dvld,
            w1_valid, r1_valid, r1_resp, r1_dvld};
    checks++;
    if (outs[69:0] !== '0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", outs);
    end
    checks++;
    if (r1_data !== 32'h0) begin
      errors++; $display("FAIL reset_rdata1 got %h expected 0", r1_data);
    end
    w0_ready = 0; r0_ready = 0; w1_ready = 0; r1_ready = 0;
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_zero_wait();
    @(posedge clk); #1;
    w0_ready = 1; w0_addr = 32'h0000_1100; w0_data = 32'hDEAD_BEEF; w0_strb = 4'hF;
    @(negedge clk);
    checks++;
    if (w0_valid !== 1'b1) begin
      errors++; $display("FAIL zw_wvalid got %b expected 1", w0_valid);
    end
    @(posedge clk); #1;
    w0_ready = 0; r0_ready = 1; r0_addr = 32'h0000_1100;
    @(negedge clk);
    checks++;
    if (r0_valid !== 1'b1 || r0_dvld !== 1'b0) begin
      errors++; $display("FAIL zw_rvalid got rvalid=%b vld=%b expected 1/0", r0_valid, r0_dvld);
    end
    @(posedge clk); #1 r0_ready = 0;
    @(negedge clk);
    checks++;
    if (r0_dvld !== 1'b1 || r0_data !== 32'hDEAD_BEEF || r0_resp !== 1'b1) begin
      errors++; $display("FAIL zw_rdata got vld=%b resp=%b data=%h expected 1/1/deadbeef",
                         r0_dvld, r0_resp, r0_data);
    end
    @(negedge clk);
    checks++;
    if (r0_dvld !== 1'b0 || r0_data !== 32'hDEAD_BEEF || r0_resp !== 1'b1) begin
      errors++; $display("FAIL zw_hold got vld=%b resp=%b data=%h expected 0/1/deadbeef",
                         r0_dvld, r0_resp, r0_data);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] d; logic ok, vld;
    wr0(32'h0000_1200, 32'h1122_3344, 4'hF);
    wr0(32'h0000_1200, 32'hAABB_CCDD, 4'b0101);
    rd0(32'h0000_1200, d, ok, vld);
    checks++;
    if (d !== 32'h11BB_33DD || ok !== 1'b1 || vld !== 1'b1) begin
      errors++; $display("FAIL strobe_0101 got %h resp=%b vld=%b expected 11bb33dd/1/1", d, ok, vld);
    end
    wr0(32'h0000_1200, 32'hFFFF_FFFF, 4'b0000);
    rd0(32'h0000_1200, d, ok, vld);
    checks++;
    if (d !== 32'h11BB_33DD) begin
      errors++; $display("FAIL strobe_0000 got %h expected 11bb33dd", d);
    end
    wr0(32'h0000_1200, 32'h5566_7788, 4'b1010);
    rd0(32'h0000_1200, d, ok, vld);
    checks++;
    if (d !== 32'h55BB_77DD) begin
      errors++; $display("FAIL strobe_1010 got %h expected 55bb77dd", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic ok, vld;
    wr0(32'h0000_1300, 32'h0000_0001, 4'hF);
    @(posedge clk); #1;
    w0_ready = 1; w0_addr = 32'h0000_1300; w0_data = 32'h0000_0002; w0_strb = 4'hF;
    r0_ready = 1; r0_addr = 32'h0000_1300;
    @(negedge clk);
    checks++;
    if (w0_valid !== 1'b1 || r0_valid !== 1'b1) begin
      errors++; $display("FAIL coll_accept got w=%b r=%b expected 1/1", w0_valid, r0_valid);
    end
    @(posedge clk); #1;
    w0_ready = 0; r0_ready = 0;
    @(negedge clk);
    checks++;
    if (r0_dvld !== 1'b1 || r0_data !== 32'h0000_0001) begin
      errors++; $display("FAIL coll_old got vld=%b data=%h expected 1/00000001", r0_dvld, r0_data);
    end
    rd0(32'h0000_1300, d, ok, vld);
    checks++;
    if (d !== 32'h0000_0002) begin
      errors++; $display("FAIL coll_new got %h expected 00000002", d);
    end
  endtask

  task automatic test_wait_states();
    @(posedge clk); #1;
    w1_ready = 1; w1_addr = 32'h40; w1_data = 32'hCAFE_F00D; w1_strb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (w1_valid !== (c == 2)) begin
        errors++; $display("FAIL ws_wvalid_c%0d got %b expected %b", c, w1_valid, (c == 2));
      end
      @(posedge clk);
    end
    #1 w1_ready = 0;
    @(posedge clk); #1;
    r1_ready = 1; r1_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (r1_valid !== (c == 3) || r1_dvld !== 1'b0) begin
        errors++; $display("FAIL ws_rvalid_c%0d got rvalid=%b vld=%b expected %b/0",
                           c, r1_valid, r1_dvld, (c == 3));
      end
      @(posedge clk);
    end
    #1 r1_ready = 0;
    @(negedge clk);
    checks++;
    if (r1_dvld !== 1'b1 || r1_data !== 32'hCAFE_F00D || r1_resp !== 1'b1) begin
      errors++; $display("FAIL ws_rdata got vld=%b resp=%b data=%h expected 1/1/cafef00d",
                         r1_dvld, r1_resp, r1_data);
    end
  endtask

  task automatic test_withdraw();
    logic seen;
    seen = 0;
    @(posedge clk); #1;
    r1_ready = 1; r1_addr = 32'h40;
    repeat (2) begin
      @(negedge clk); seen = seen | r1_valid | r1_dvld;
      @(posedge clk);
    end
    #1 r1_ready = 0;
    repeat (6) begin
      @(negedge clk); seen = seen | r1_valid | r1_dvld;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL withdraw got valid/vld=%b expected 0", seen);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic ok, vld;
    @(posedge clk); #1;
    w0_ready = 1; w0_strb = 4'hF;
    for (int unsigned i = 0; i < 256; i++) begin
      w0_addr = 32'h0000_1000 + 4 * i;
      w0_data = 32'hA500_0000 | i;
      @(posedge clk); #1;
    end
    w0_ready = 0;
    rd0(32'h0000_1400, d, ok, vld);
    checks++;
    if (d !== 32'h0 || ok !== 1'b0 || vld !== 1'b1) begin
      errors++; $display("FAIL oor_above got %h resp=%b vld=%b expected 0/0/1", d, ok, vld);
    end
    rd0(32'h0000_0FFC, d, ok, vld);
    checks++;
    if (d !== 32'h0 || ok !== 1'b0 || vld !== 1'b1) begin
      errors++; $display("FAIL oor_below got %h resp=%b vld=%b expected 0/0/1", d, ok, vld);
    end
    wr0(32'h0000_1400, 32'hFFFF_FFFF, 4'hF);
    wr0(32'h0000_0FFC, 32'hFFFF_FFFF, 4'hF);
    for (int unsigned i = 0; i < 256; i++) begin
      rd0(32'h0000_1000 + 4 * i, d, ok, vld);
      checks++;
      if (d !== (32'hA500_0000 | i) || ok !== 1'b1) begin
        errors++; $display("FAIL oor_word%0d got %h resp=%b expected %h/1",
                           i, d, ok, 32'hA500_0000 | i);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d; logic ok; logic seen; logic [69:0] outs;
    seen = 0;
    wr1(32'h80, 32'h5555_AAAA, 4'hF);
    @(posedge clk); #1;
    w1_ready = 1; w1_addr = 32'h80; w1_data = 32'hFFFF_FFFF; w1_strb = 4'hF;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    outs = {w0_valid, r0_valid, r0_resp, r0_data, r0_dvld,
            w1_valid, r1_valid, r1_resp, r1_dvld};
    checks++;
    if (outs[69:0] !== '0 || r1_data !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs got %h/%h expected 0", outs, r1_data);
    end
    repeat (3) begin
      @(negedge clk); seen = seen | w1_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrst_wvalid got %b expected 0", seen);
    end
    @(posedge clk); #1 w1_ready = 0;
    @(posedge clk); #1 reset = 0;
    rd1(32'h80, d, ok);
    checks++;
    if (d !== 32'h5555_AAAA || ok !== 1'b1) begin
      errors++; $display("FAIL midrst_word got %h resp=%b expected 5555aaaa/1", d, ok);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_strobes();
    test_collision();
    test_wait_states();
    test_withdraw();
    test_out_of_range();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
